// File: rtl/power_peak_search.sv
// rtl/power_peak_search.sv - per-frame peak bin search over an 8-lane power spectrum stream
//
// Consumes one frame of the 2-column x LANES-lane power stream and reports the
// largest bin, its bin number, and how many bins exceed a threshold that is
// latched on the first beat of the frame.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   valid                           high for every beat of a frame
//   col_1, col_2                    LANES packed power samples per column
//   out_index_col1, out_index_col2  column index; lane k is bin LANES*index+k
//   threshold                       count level, captured on the first beat
//   peak_valid                      one-cycle result strobe
//   peak_value, peak_bin            maximum power and its bin number
//   above_cnt                       bins with power strictly above threshold
//   frame_err                       frame ended before NUM_BINS bins arrived
//   busy                            frame in progress
//
// Build option: define POWER_PEAK_DC_SKIP_EN to exclude bins 0..DC_GUARD-1
// from both the maximum search and the threshold count.

module power_peak_search #(
    parameter int DATA_WIDTH  = 53,
    parameter int INDEX_WIDTH = 11,
    parameter int BIN_WIDTH   = 13,
    parameter int NUM_BINS    = 8192,
    parameter int LANES       = 4,
    parameter int DC_GUARD    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        valid,
    input  logic [LANES*DATA_WIDTH-1:0] col_1,
    input  logic [LANES*DATA_WIDTH-1:0] col_2,
    input  logic [INDEX_WIDTH-1:0]      out_index_col1,
    input  logic [INDEX_WIDTH-1:0]      out_index_col2,
    input  logic [DATA_WIDTH-1:0]       threshold,
    output logic                        peak_valid,
    output logic [DATA_WIDTH-1:0]       peak_value,
    output logic [BIN_WIDTH-1:0]        peak_bin,
    output logic [BIN_WIDTH:0]          above_cnt,
    output logic                        frame_err,
    output logic                        busy
);

    localparam int CANDS = 2 * LANES;
    localparam int CNT_W = $clog2(CANDS + 1);
    localparam logic [BIN_WIDTH:0]   FULL_CNT  = (BIN_WIDTH + 1)'(NUM_BINS);
    localparam logic [BIN_WIDTH:0]   ONE_COL   = (BIN_WIDTH + 1)'(LANES);
    localparam logic [BIN_WIDTH:0]   TWO_COL   = (BIN_WIDTH + 1)'(2 * LANES);
    localparam logic [BIN_WIDTH-1:0] GUARD_BIN = BIN_WIDTH'(DC_GUARD);
`ifdef POWER_PEAK_DC_SKIP_EN
    localparam logic DC_SKIP = 1'b1;
`else
    localparam logic DC_SKIP = 1'b0;
`endif
    // With the guard in place the search starts from bin DC_GUARD so an empty
    // search reports the first eligible bin rather than bin 0.
    localparam logic [BIN_WIDTH-1:0] INIT_BIN = DC_SKIP ? GUARD_BIN : '0;

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

    state_t                  state;
    logic [BIN_WIDTH:0]      bin_cnt;
    logic [1:0]              beat_cnt;   // saturates at 2: only "beat >= 2" matters
    logic [DATA_WIDTH-1:0]   thr_q;
    logic                    flush_cnt;

    logic                    s1_valid;
    logic                    s1_has;
    logic [DATA_WIDTH-1:0]   s1_max;
    logic [BIN_WIDTH-1:0]    s1_bin;
    logic [CNT_W-1:0]        s1_cnt;

    logic [DATA_WIDTH-1:0]   run_max;
    logic [BIN_WIDTH-1:0]    run_bin;
    logic [BIN_WIDTH:0]      run_cnt;

    logic                    take;
    logic                    start;
    logic                    col2_en;
    logic [DATA_WIDTH-1:0]   thr_eff;
    logic [BIN_WIDTH:0]      next_cnt;
    logic [DATA_WIDTH-1:0]   c_val [CANDS];
    logic [BIN_WIDTH-1:0]    c_bin [CANDS];
    logic                    c_en  [CANDS];
    logic                    b_has;
    logic [DATA_WIDTH-1:0]   b_max;
    logic [BIN_WIDTH-1:0]    b_bin;
    logic [CNT_W-1:0]        b_cnt;

    // Larger power wins; equal power goes to the lower bin number, so the
    // result is independent of the order in which bins arrive.
    function automatic logic better(input logic [DATA_WIDTH-1:0] av, input logic [BIN_WIDTH-1:0] ab,
                                    input logic [DATA_WIDTH-1:0] bv, input logic [BIN_WIDTH-1:0] bb);
        return (av > bv) || ((av == bv) && (ab < bb));
    endfunction

    always_comb begin
        start    = valid && (state == IDLE);
        take     = valid && ((state == IDLE) || (state == SCAN));
        // The first beat is consumed in IDLE, before thr_q has been loaded.
        thr_eff  = (state == IDLE) ? threshold : thr_q;
        col2_en  = (state == SCAN) && (beat_cnt == 2'd2);
        next_cnt = bin_cnt + ((beat_cnt == 2'd2) ? TWO_COL : ONE_COL);

        for (int k = 0; k < LANES; k++) begin
            c_val[k]         = col_1[k*DATA_WIDTH +: DATA_WIDTH];
            c_bin[k]         = BIN_WIDTH'(int'(out_index_col1) * LANES + k);
            c_en[k]          = 1'b1;
            c_val[LANES + k] = col_2[k*DATA_WIDTH +: DATA_WIDTH];
            c_bin[LANES + k] = BIN_WIDTH'(int'(out_index_col2) * LANES + k);
            c_en[LANES + k]  = col2_en;
        end

        b_has = 1'b0;
        b_max = '0;
        b_bin = '0;
        b_cnt = '0;
        for (int i = 0; i < CANDS; i++) begin
            if (c_en[i] && !(DC_SKIP && (c_bin[i] < GUARD_BIN))) begin
                if (c_val[i] > thr_eff) begin
                    b_cnt = b_cnt + CNT_W'(1);
                end
                if (!b_has || better(c_val[i], c_bin[i], b_max, b_bin)) begin
                    b_has = 1'b1;
                    b_max = c_val[i];
                    b_bin = c_bin[i];
                end
            end
        end
    end

    // Stage 1 holds the per-beat winner; stage 2 folds it into the frame result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_has   <= 1'b0;
            s1_max   <= '0;
            s1_bin   <= '0;
            s1_cnt   <= '0;
            run_max  <= '0;
            run_bin  <= '0;
            run_cnt  <= '0;
        end else begin
            s1_valid <= take;
            if (take) begin
                s1_has <= b_has;
                s1_max <= b_max;
                s1_bin <= b_bin;
                s1_cnt <= b_cnt;
            end
            if (start) begin
                run_max <= '0;
                run_bin <= INIT_BIN;
                run_cnt <= '0;
            end else if (s1_valid) begin
                if (s1_has && better(s1_max, s1_bin, run_max, run_bin)) begin
                    run_max <= s1_max;
                    run_bin <= s1_bin;
                end
                run_cnt <= run_cnt + (BIN_WIDTH + 1)'(s1_cnt);
            end
        end
    end

    // When the bin count fills, the last beat is still in stage 1, so two
    // flush cycles are needed. When valid falls, the first non-valid SCAN
    // cycle already drains stage 1, so one flush cycle is enough. Both paths
    // raise peak_valid three cycles after the last consumed beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bin_cnt    <= '0;
            beat_cnt   <= '0;
            thr_q      <= '0;
            flush_cnt  <= 1'b0;
            peak_valid <= 1'b0;
            peak_value <= '0;
            peak_bin   <= '0;
            above_cnt  <= '0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            peak_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
                        thr_q    <= threshold;
                        bin_cnt  <= ONE_COL;
                        beat_cnt <= 2'd1;
                        busy     <= 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (valid) begin
                        bin_cnt <= next_cnt;
                        if (beat_cnt != 2'd2) begin
                            beat_cnt <= beat_cnt + 2'd1;
                        end
                        if (next_cnt == FULL_CNT) begin
                            flush_cnt <= 1'b1;
                            state     <= FLUSH;
                        end
                    end else begin
                        flush_cnt <= 1'b0;
                        state     <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (flush_cnt) begin
                        flush_cnt <= 1'b0;
                    end else begin
                        peak_valid <= 1'b1;
                        peak_value <= run_max;
                        peak_bin   <= run_bin;
                        above_cnt  <= run_cnt;
                        frame_err  <= (bin_cnt != FULL_CNT);
                        state      <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_power_peak_search.sv
// tb/tb_power_peak_search.sv - scoreboard bench for power_peak_search

module tb_power_peak_search;

    localparam int DW = 53;
    localparam int IW = 11;
    localparam int BW = 13;
    localparam int LN = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             valid = 1'b0;
    logic [LN*DW-1:0] col_1 = '0;
    logic [LN*DW-1:0] col_2 = '0;
    logic [IW-1:0]    out_index_col1 = '0;
    logic [IW-1:0]    out_index_col2 = '0;
    logic [DW-1:0]    threshold = '0;
    logic             peak_valid;
    logic [DW-1:0]    peak_value;
    logic [BW-1:0]    peak_bin;
    logic [BW:0]      above_cnt;
    logic             frame_err;
    logic             busy;

    power_peak_search dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid          (valid),
        .col_1          (col_1),
        .col_2          (col_2),
        .out_index_col1 (out_index_col1),
        .out_index_col2 (out_index_col2),
        .threshold      (threshold),
        .peak_valid     (peak_valid),
        .peak_value     (peak_value),
        .peak_bin       (peak_bin),
        .above_cnt      (above_cnt),
        .frame_err      (frame_err),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] val;
        logic [BW-1:0] bin;
        logic [BW:0]   cnt;
        logic          err;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    logic pv_d = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Sparse frame content: every bin holds f_dflt except f_b0 / f_b1.
    logic [DW-1:0] f_dflt, f_v0, f_v1;
    int            f_b0, f_b1;

    function automatic logic [DW-1:0] pw(input int bin);
        if (bin == f_b0) return f_v0;
        if (bin == f_b1) return f_v1;
        return f_dflt;
    endfunction

    // Beat b: b<2 carries column b on col_1 only (col_2 holds junk that must
    // be ignored); b>=2 carries column b on col_1 and column b+1023 on col_2.
    task automatic drive_beat(input int b, input bit junk);
        int i1, i2;
        @(posedge clk);
        #1;
        valid = 1'b1;
        if (b >= 1) threshold = '0;
        if (junk) begin
            col_1 = '1;
            col_2 = '1;
            out_index_col1 = '0;
            out_index_col2 = '0;
        end else begin
            i1 = b;
            i2 = (b < 2) ? 0 : b + 1023;
            out_index_col1 = IW'(i1);
            out_index_col2 = IW'(i2);
            for (int k = 0; k < LN; k++) begin
                col_1[k*DW +: DW] = pw(4 * i1 + k);
                col_2[k*DW +: DW] = (b < 2) ? '1 : pw(4 * i2 + k);
            end
        end
    endtask

    task automatic run_frame(input int nbeats, input int extra, input logic [DW-1:0] dflt,
                             input int b0, input logic [DW-1:0] v0, input int b1, input logic [DW-1:0] v1,
                             input logic [DW-1:0] thr, input logic [DW-1:0] ev, input int eb,
                             input int ec, input logic ee);
        exp_t e;
        int   last;
        f_dflt = dflt;
        f_b0 = b0;
        f_v0 = v0;
        f_b1 = b1;
        f_v1 = v1;
        threshold = thr;
        last = 0;
        for (int b = 0; b < nbeats; b++) begin
            drive_beat(b, 1'b0);
            last = cyc;
        end
        e.val = ev;
        e.bin = BW'(eb);
        e.cnt = (BW + 1)'(ec);
        e.err = ee;
        e.cyc = last + 3;
        sb.push_back(e);
        for (int x = 0; x < extra; x++) drive_beat(0, 1'b1);
        @(posedge clk);
        #1;
        valid = 1'b0;
        col_1 = '0;
        col_2 = '0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && sb.size() > 0; i++) @(posedge clk);
        chk("result_timeout_pending", 64'(sb.size()), 64'd0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_peak_valid"}, 64'(peak_valid), 64'd0);
        chk({tag, "_peak_value"}, 64'(peak_value), 64'd0);
        chk({tag, "_peak_bin"}, 64'(peak_bin), 64'd0);
        chk({tag, "_above_cnt"}, 64'(above_cnt), 64'd0);
        chk({tag, "_frame_err"}, 64'(frame_err), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    // Monitor: pops one expectation per peak_valid pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            pv_d = 1'b0;
        end else begin
            if (pv_d) chk("busy_after_pulse", 64'(busy), 64'd0);
            if (peak_valid) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_peak_valid: got 1 expected 0 at cycle %0d", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("peak_value", 64'(peak_value), 64'(mon_e.val));
                    chk("peak_bin", 64'(peak_bin), 64'(mon_e.bin));
                    chk("above_cnt", 64'(above_cnt), 64'(mon_e.cnt));
                    chk("frame_err", 64'(frame_err), 64'(mon_e.err));
                    chk("latency_cycle", 64'(cyc), 64'(mon_e.cyc));
                    chk("busy_during_pulse", 64'(busy), 64'd1);
                end
            end
            pv_d = peak_valid;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Single peak on col_2 lane 0, two junk beats after the frame fills.
        run_frame(1025, 2, '0, 5000, 53'h1_0000_0000, -1, '0, 53'h100,
                  53'h1_0000_0000, 5000, 1, 1'b0);
        repeat (6) @(posedge clk);
        wait_drain();

        // Cross-beat tie keeps the lower bin; every bin above threshold 0.
`ifdef POWER_PEAK_DC_SKIP_EN
        run_frame(1025, 0, 53'd1, 100, 53'hFFFF, 7000, 53'hFFFF, '0, 53'hFFFF, 100, 8188, 1'b0);
`else
        run_frame(1025, 0, 53'd1, 100, 53'hFFFF, 7000, 53'hFFFF, '0, 53'hFFFF, 100, 8192, 1'b0);
`endif
        repeat (6) @(posedge clk);
        wait_drain();

        // Huge DC bin versus a small peak at bin 3000.
`ifdef POWER_PEAK_DC_SKIP_EN
        run_frame(1025, 0, '0, 0, 53'h1F_FFFF_FFFF_FFFF, 3000, 53'h10, 53'hF, 53'h10, 3000, 1, 1'b0);
`else
        run_frame(1025, 0, '0, 0, 53'h1F_FFFF_FFFF_FFFF, 3000, 53'h10, 53'hF,
                  53'h1F_FFFF_FFFF_FFFF, 0, 2, 1'b0);
`endif
        repeat (6) @(posedge clk);
        wait_drain();

        // Short frame: valid drops after 500 beats.
        run_frame(500, 0, '0, 900, 53'h55, -1, '0, 53'h54, 53'h55, 900, 1, 1'b1);
        repeat (6) @(posedge clk);
        wait_drain();

        // Reset in the middle of a frame.
        f_dflt = '0;
        f_b0 = -1;
        f_b1 = -1;
        threshold = 53'h3;
        for (int b = 0; b < 300; b++) drive_beat(b, 1'b0);
        drive_beat(300, 1'b0);
        chk("busy_mid_frame", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        chk_outputs_zero("midreset");
        valid = 1'b0;
        col_1 = '0;
        col_2 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        chk("post_reset_bin", 64'(peak_bin), 64'd0);
        run_frame(1025, 0, '0, 12, 53'h7, -1, '0, 53'h7, 53'h7, 12, 0, 1'b0);
        repeat (6) @(posedge clk);
        wait_drain();

        // Back-to-back frames with exactly 4 idle cycles; threshold recaptured.
        run_frame(1025, 0, '0, 8191, 53'h3, -1, '0, 53'h2, 53'h3, 8191, 1, 1'b0);
        repeat (3) @(posedge clk);
`ifdef POWER_PEAK_DC_SKIP_EN
        run_frame(1025, 0, '0, 1, 53'h9, 8000, 53'h5, 53'h6, 53'h5, 8000, 0, 1'b0);
`else
        run_frame(1025, 0, '0, 1, 53'h9, 8000, 53'h5, 53'h6, 53'h9, 1, 1, 1'b0);
`endif
        repeat (6) @(posedge clk);
        wait_drain();

        // Tie inside one beat (col_1 lanes 1 and 3), short frame.
        run_frame(600, 0, '0, 2003, 53'h77, 2001, 53'h77, 53'h76, 53'h77, 2001, 2, 1'b1);
        repeat (6) @(posedge clk);
        wait_drain();

        // Short all-zero frame.
`ifdef POWER_PEAK_DC_SKIP_EN
        run_frame(20, 0, '0, -1, '0, -1, '0, '0, '0, 4, 0, 1'b1);
`else
        run_frame(20, 0, '0, -1, '0, -1, '0, '0, '0, 0, 0, 1'b1);
`endif
        repeat (6) @(posedge clk);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/power_peak_search.md
Name: power_peak_search

Overview:
- Sits directly downstream of the power/integral stage in the FFT chain.
- Consumes its 8-lane (2 columns x 4 lanes) 53-bit power spectrum stream for one 16384-point real FFT frame (8192 bins).
- Reports the maximum-power bin, its index, and the count of bins above a programmable threshold.
- Results feed the frequency-estimation/control logic.

Parameters:
- DATA_WIDTH, 53, width of each power sample.
- INDEX_WIDTH, 11, width of the incoming column index.
- BIN_WIDTH, 13, width of the bin number (log2 NUM_BINS).
- NUM_BINS, 8192, bins per frame.
- LANES, 4, samples per column per beat.
- DC_GUARD, 4, number of low bins excluded when DC skip is compiled in.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- valid  in  1  power stream valid; high for the whole frame, low between frames.
- col_1  in  LANES*DATA_WIDTH  column-1 power samples; lane k = bin 4*out_index_col1+k.
- col_2  in  LANES*DATA_WIDTH  column-2 power samples; lane k = bin 4*out_index_col2+k.
- out_index_col1  in  INDEX_WIDTH  column-1 index.
- out_index_col2  in  INDEX_WIDTH  column-2 index.
- threshold  in  DATA_WIDTH  unsigned level for bin counting; sampled at frame start.
- peak_valid  out  1  one-cycle pulse; results valid.
- peak_value  out  DATA_WIDTH  maximum power of the frame.
- peak_bin  out  BIN_WIDTH  bin number of the maximum.
- above_cnt  out  BIN_WIDTH+1  number of bins with power strictly greater than threshold.
- frame_err  out  1  high with peak_valid if the frame ended short of NUM_BINS bins.
- busy  out  1  high from frame start until peak_valid.

Behaviour:
- Reset: all outputs 0, state IDLE, running max 0, bin counter 0.
- All samples are unsigned.
- FSM states and transitions:
  - IDLE -> SCAN on the first cycle valid=1. threshold is captured in that cycle; busy rises the next cycle.
  - SCAN: beat counter counts valid cycles.
    - Beats 0 and 1: only col_1 is qualified (4 bins each).
    - Beat >= 2: col_1 and col_2 are both qualified (8 bins).
    - Bin counter adds 4 or 8 per beat.
  - SCAN -> FLUSH when valid falls, or when the bin counter reaches NUM_BINS (extra valid beats after that are ignored).
  - FLUSH: drains the 2-stage compare pipeline.
  - DONE: peak_valid=1 for one cycle, then IDLE.
- Pipeline:
  - Stage 1 registers the per-beat max of the qualified lanes plus the per-beat count of lanes > threshold (0..8).
  - Stage 2 updates the running max and accumulates the count.
- Latency: peak_valid is asserted exactly 3 cycles after the last consumed valid beat.
- Outputs peak_value, peak_bin, above_cnt and frame_err hold until the next peak_valid.
- Tie rule: equal powers keep the lowest bin number, both within a beat and across beats (strict > to replace).
- All-zero frame: peak_value=0, peak_bin=0.
- Short frame (valid falls with bin count < NUM_BINS): result is still reported over the bins received; frame_err=1.
- valid rising while in FLUSH/DONE: ignored. Frames must be separated by at least 4 idle cycles.
- rst_n asserted mid-frame: immediate return to IDLE, no peak_valid, outputs cleared.
- above_cnt saturates naturally; maximum value NUM_BINS fits in BIN_WIDTH+1 bits.

Optional Feature:
- Macro POWER_PEAK_DC_SKIP_EN.
  - Defined: bins 0..DC_GUARD-1 are excluded from the max search and from above_cnt; an all-excluded/zero frame reports peak_bin=DC_GUARD.
  - Undefined: every bin participates and DC_GUARD is unused.

Test Plan:
- Full 1025-beat frame, all bins 0 except bin 5000 = 0x1_0000_0000 (col_2 lane 0, out_index_col2=1250), threshold=0x100 -> peak_valid 3 cycles after last beat; peak_value=0x100000000, peak_bin=5000, above_cnt=1, frame_err=0.
- Full frame, bins 100 and 7000 both = 0xFFFF, rest 1, threshold=0 -> peak_bin=100 (tie keeps lowest), above_cnt=8192.
- Full frame with bin 0 = 0x1F_FFFF_FFFF_FFFF and bin 3000 = 0x10 -> macro undefined: peak_bin=0; with POWER_PEAK_DC_SKIP_EN: peak_bin=3000, peak_value=0x10.
- valid dropped after 500 beats, max at bin 900 = 0x55 -> peak_valid with frame_err=1, peak_bin=900, busy low the cycle after the pulse.
- rst_n pulsed low mid-SCAN at beat 300 -> no peak_valid; all outputs 0. Next full frame (peak bin 12 = 0x7) -> peak_bin=12, frame_err=0.
- Two back-to-back full frames with 4 idle cycles, peaks at bin 8191 then bin 1 -> two peak_valid pulses reporting 8191 then 1; threshold recaptured per frame.
